// File: rtl/start_token_srl_fifo.sv
// ---------------------------------------------------------------------------
// start_token_srl_fifo
//   Small token FIFO built on a shift register. A push shifts every entry up
//   one slot and inserts the new word at index 0. The oldest entry therefore
//   sits at index cnt-1, and the read pointer follows the occupancy count.
//   Both flags are registered. There is no bypass path: a word pushed on
//   edge N becomes visible after edge N.
//
// Parameters
//   DATA_WIDTH  token/data width
//   ADDR_WIDTH  pointer width, 2**ADDR_WIDTH >= DEPTH
//   DEPTH       capacity in entries, 1..2**ADDR_WIDTH
//
// Ports
//   ap_clk             clock, rising edge
//   ap_rst_n           asynchronous active-low reset, released synchronously
//   if_write_ce        write-side clock enable
//   if_write           write request
//   if_din             write data
//   if_full_n          1 = space available (registered)
//   if_read_ce         read-side clock enable
//   if_read            read request
//   if_dout            oldest entry, combinational from storage
//   if_empty_n         1 = data available (registered)
//   if_num_data_valid  occupancy count, present only when
//                      START_TOKEN_FIFO_USEDW_EN is defined
// ---------------------------------------------------------------------------
module start_token_srl_fifo #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n
`ifdef START_TOKEN_FIFO_USEDW_EN
    ,
    output logic [ADDR_WIDTH:0]   if_num_data_valid
`endif
);

    logic [DATA_WIDTH-1:0] storage [DEPTH];
    logic [ADDR_WIDTH:0]   cnt;
    logic [ADDR_WIDTH:0]   cnt_nxt;
    logic [ADDR_WIDTH-1:0] ptr;
    logic                  push;
    logic                  pop;

    // Requests are qualified by the registered flags. A write while full
    // or a read while empty has no effect.
    assign push = if_write & if_write_ce & if_full_n;
    assign pop  = if_read  & if_read_ce  & if_empty_n;

    // Storage is intentionally left unreset. Its contents are only
    // meaningful while if_empty_n is high.
    always_ff @(posedge ap_clk) begin
        if (push) begin
            storage[0] <= if_din;
            for (int i = 1; i < DEPTH; i++) begin
                storage[i] <= storage[i-1];
            end
        end
    end

    always_comb begin
        cnt_nxt = cnt;
        case ({push, pop})
            2'b10:   cnt_nxt = cnt + (ADDR_WIDTH+1)'(1);
            2'b01:   cnt_nxt = cnt - (ADDR_WIDTH+1)'(1);
            default: cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt        <= '0;
            if_empty_n <= 1'b0;
            if_full_n  <= 1'b1;
        end else begin
            cnt        <= cnt_nxt;
            if_empty_n <= (cnt_nxt != '0);
            if_full_n  <= (cnt_nxt < (ADDR_WIDTH+1)'(DEPTH));
        end
    end

    // The oldest entry is at cnt-1. The pointer saturates at 0 when the
    // FIFO is empty; dout is don't-care in that state.
    always_comb begin
        if (cnt == '0) begin
            ptr = '0;
        end else begin
            ptr = ADDR_WIDTH'(cnt - (ADDR_WIDTH+1)'(1));
        end
    end

    always_comb begin
        if_dout = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ptr == ADDR_WIDTH'(i)) begin
                if_dout = storage[i];
            end
        end
    end

`ifdef START_TOKEN_FIFO_USEDW_EN
    assign if_num_data_valid = cnt;
`endif

endmodule

// File: tb/tb_start_token_srl_fifo.sv
// ---------------------------------------------------------------------------
// tb_start_token_srl_fifo
//   Three FIFO instances (DEPTH 1, 2 and 4) share one set of inputs. Each
//   instance has a queue model that tracks the accepted pushes and pops.
//   Directed vectors check hand-computed values. A random phase then
//   compares flags and dout against the models.
// ---------------------------------------------------------------------------
module tb_start_token_srl_fifo;

    logic       clk;
    logic       rst_n;
    logic       wr_ce;
    logic       wr;
    logic [7:0] din;
    logic       rd_ce;
    logic       rd;
    logic [2:0] full_n;
    logic [2:0] empty_n;
    logic [7:0] dout [3];
`ifdef START_TOKEN_FIFO_USEDW_EN
    logic [1:0] nd1;
    logic [1:0] nd2;
    logic [2:0] nd4;
`endif

    logic [7:0] q [3][$];
    int         dep [3];
    int         n_chk;
    int         n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    start_token_srl_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(1), .DEPTH(1)) u_d1 (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .if_write_ce(wr_ce), .if_write(wr), .if_din(din), .if_full_n(full_n[0]),
        .if_read_ce(rd_ce), .if_read(rd), .if_dout(dout[0]), .if_empty_n(empty_n[0])
`ifdef START_TOKEN_FIFO_USEDW_EN
        , .if_num_data_valid(nd1)
`endif
    );

    start_token_srl_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(1), .DEPTH(2)) u_d2 (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .if_write_ce(wr_ce), .if_write(wr), .if_din(din), .if_full_n(full_n[1]),
        .if_read_ce(rd_ce), .if_read(rd), .if_dout(dout[1]), .if_empty_n(empty_n[1])
`ifdef START_TOKEN_FIFO_USEDW_EN
        , .if_num_data_valid(nd2)
`endif
    );

    start_token_srl_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4)) u_d4 (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .if_write_ce(wr_ce), .if_write(wr), .if_din(din), .if_full_n(full_n[2]),
        .if_read_ce(rd_ce), .if_read(rd), .if_dout(dout[2]), .if_empty_n(empty_n[2])
`ifdef START_TOKEN_FIFO_USEDW_EN
        , .if_num_data_valid(nd4)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic drv(input logic w, input logic [7:0] d, input logic r);
        wr_ce = 1'b1;
        rd_ce = 1'b1;
        wr    = w;
        din   = d;
        rd    = r;
    endtask

    // One clock: the model updates with the pre-edge view, and the DUT is
    // then sampled 1 time unit after the edge.
    task automatic tick();
        bit pu [3];
        bit po [3];
        for (int k = 0; k < 3; k++) begin
            pu[k] = wr & wr_ce & (q[k].size() < dep[k]);
            po[k] = rd & rd_ce & (q[k].size() > 0);
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (po[k]) void'(q[k].pop_front());
            if (pu[k]) q[k].push_back(din);
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drv(1'b0, 8'h00, 1'b0);
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) q[k].delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        dep[0] = 1;
        dep[1] = 2;
        dep[2] = 4;
        rst_n  = 1'b0;
        drv(1'b0, 8'h00, 1'b0);
        #12;
        chk("rst_empty_d1", empty_n[0], 1'b0);
        chk("rst_full_d1", full_n[0], 1'b1);
        chk("rst_empty_d4", empty_n[2], 1'b0);
        chk("rst_full_d4", full_n[2], 1'b1);
`ifdef START_TOKEN_FIFO_USEDW_EN
        chk("rst_usedw_d4", nd4, 3'd0);
`endif
        do_reset();

        // Single push/pop, one-cycle latency
        drv(1'b1, 8'hA5, 1'b0); tick();
        chk("lat_empty_d2", empty_n[1], 1'b1);
        chk("lat_dout_d2", dout[1], 8'hA5);
        chk("lat_full_d2", full_n[1], 1'b1);
        chk("lat_full_d1", full_n[0], 1'b0);
        drv(1'b0, 8'h00, 1'b1); tick();
        chk("pop_empty_d2", empty_n[1], 1'b0);
        chk("pop_full_d1", full_n[0], 1'b1);

        // Fill DEPTH=2, a third write is dropped
        do_reset();
        drv(1'b1, 8'h01, 1'b0); tick();
        chk("fill1_full_d2", full_n[1], 1'b1);
        drv(1'b1, 8'h00, 1'b0); tick();
        chk("fill2_full_d2", full_n[1], 1'b0);
        chk("fill2_dout_d2", dout[1], 8'h01);
        drv(1'b1, 8'hFF, 1'b0); tick();
        chk("drop_full_d2", full_n[1], 1'b0);
        chk("drop_dout_d2", dout[1], 8'h01);
        drv(1'b0, 8'h00, 1'b1); tick();
        chk("drain1_dout_d2", dout[1], 8'h00);
        chk("drain1_full_d2", full_n[1], 1'b1);
        tick();
        chk("drain2_empty_d2", empty_n[1], 1'b0);

        // Full DEPTH=2 with simultaneous write and read
        do_reset();
        drv(1'b1, 8'h01, 1'b0); tick();
        drv(1'b1, 8'h02, 1'b0); tick();
        drv(1'b1, 8'h03, 1'b1); tick();
        chk("fullrw_full_d2", full_n[1], 1'b1);
        chk("fullrw_empty_d2", empty_n[1], 1'b1);
        chk("fullrw_dout_d2", dout[1], 8'h02);
`ifdef START_TOKEN_FIFO_USEDW_EN
        chk("fullrw_usedw_d2", nd2, 2'd1);
`endif
        drv(1'b0, 8'h00, 1'b1); tick();
        chk("fullrw_drop_d2", empty_n[1], 1'b0);

        // DEPTH=4 with two entries, simultaneous push and pop
        do_reset();
        drv(1'b1, 8'h11, 1'b0); tick();
        drv(1'b1, 8'h22, 1'b0); tick();
        chk("pp_pre_dout_d4", dout[2], 8'h11);
        drv(1'b1, 8'h33, 1'b1); tick();
        chk("pp_dout_d4", dout[2], 8'h22);
        chk("pp_empty_d4", empty_n[2], 1'b1);
        chk("pp_full_d4", full_n[2], 1'b1);
`ifdef START_TOKEN_FIFO_USEDW_EN
        chk("pp_usedw_d4", nd4, 3'd2);
`endif
        drv(1'b0, 8'h00, 1'b1); tick();
        chk("pp_pop1_d4", dout[2], 8'h33);
        tick();
        chk("pp_pop2_d4", empty_n[2], 1'b0);

        // DEPTH=1 alternates; a full write with a read keeps only the pop
        do_reset();
        drv(1'b1, 8'h5A, 1'b0); tick();
        chk("d1_full", full_n[0], 1'b0);
        chk("d1_dout", dout[0], 8'h5A);
        drv(1'b1, 8'h6B, 1'b1); tick();
        chk("d1_rw_full", full_n[0], 1'b1);
        chk("d1_rw_empty", empty_n[0], 1'b0);
        drv(1'b1, 8'h6B, 1'b0); tick();
        chk("d1_dout2", dout[0], 8'h6B);

        // Write enable low: the request is ignored
        do_reset();
        drv(1'b1, 8'h77, 1'b0);
        wr_ce = 1'b0;
        tick();
        chk("wce_empty_d4", empty_n[2], 1'b0);

        // Fill DEPTH=4 completely, then a read with a write
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drv(1'b1, 8'(i), 1'b0); tick();
        end
        chk("d4_full", full_n[2], 1'b0);
        chk("d4_full_dout", dout[2], 8'h01);
        drv(1'b1, 8'h05, 1'b1); tick();
        chk("d4_rw_full", full_n[2], 1'b1);
        chk("d4_rw_dout", dout[2], 8'h02);

        // Reset asserted mid-operation with three of four entries held
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            drv(1'b1, 8'(i), 1'b0); tick();
        end
        drv(1'b0, 8'h00, 1'b0);
        chk("mid_pre_empty_d4", empty_n[2], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_empty_d4", empty_n[2], 1'b0);
        chk("mid_full_d4", full_n[2], 1'b1);
`ifdef START_TOKEN_FIFO_USEDW_EN
        chk("mid_usedw_d4", nd4, 3'd0);
`endif
        for (int k = 0; k < 3; k++) q[k].delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_empty_d4", empty_n[2], 1'b0);
        drv(1'b1, 8'hAA, 1'b0); tick();
        chk("post_push_empty_d4", empty_n[2], 1'b1);
        chk("post_push_dout_d4", dout[2], 8'hAA);

        // Random traffic checked against the queue models
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            wr_ce = ($urandom_range(0, 3) != 0);
            rd_ce = ($urandom_range(0, 3) != 0);
            wr    = 1'($urandom_range(0, 1));
            rd    = 1'($urandom_range(0, 1));
            din   = 8'($urandom_range(0, 255));
            for (int k = 0; k < 3; k++) begin
                chk("rnd_empty", empty_n[k], (q[k].size() > 0));
                chk("rnd_full", full_n[k], (q[k].size() < dep[k]));
                if (q[k].size() > 0) chk("rnd_dout", dout[k], q[k][0]);
            end
`ifdef START_TOKEN_FIFO_USEDW_EN
            chk("rnd_usedw_d4", nd4, q[2].size());
`endif
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
